// File: rtl/rom_loader.sv
// Boot-time ROM programmer: parses SYNC/LEN/data/CSUM byte frames from the serial
// receiver, issues 16-bit ROM writes and keeps the ROM write-protected outside a load.
module rom_loader #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   ROM_START = 16'h0000,
    parameter int                 DEPTH     = 32768,
    parameter logic [7:0]         SYNC_BYTE = 8'hB4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             wr_en,
    input  logic             wr_ready,
    output logic             write_protect,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] words_written
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_WRITE,
        S_CSUM_LO,
        S_CSUM_HI,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [7:0]       lo_q, lo_d;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic [WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic             wp_q, wp_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] ww_q, ww_d;
    logic             rx_ready_c;
    logic             accept;
    logic [WIDTH-1:0] rx_word;

    function automatic logic [WIDTH-1:0] csum_add(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] word);
        return acc + word;
    endfunction

    function automatic logic len_over(input logic [WIDTH-1:0] len);
        return 32'(len) > 32'(DEPTH);
    endfunction

    // Frame fields are little-endian: the byte on rx_data is always the high half.
    assign rx_word = {rx_data, lo_q};

    always_comb begin
        rx_ready_c = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR:      rx_ready_c = enable;
            S_LEN_LO, S_LEN_HI,
            S_DATA_LO, S_DATA_HI,
            S_CSUM_LO, S_CSUM_HI:         rx_ready_c = 1'b1;
            default:                      rx_ready_c = 1'b0;
        endcase
    end

    assign accept = rx_valid && rx_ready_c;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        lo_d      = lo_q;
        csum_d    = csum_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = wr_en_q;
        wp_d      = wp_q;
        done_d    = done_q;
        error_d   = error_q;
        ww_d      = ww_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN_LO;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    ww_d    = '0;
                    csum_d  = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    lo_d    = rx_data;
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = rx_word;
                    if (len_over(rx_word)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else if (rx_word == '0) begin
                        state_d = S_CSUM_LO;
                    end else begin
                        // ROM becomes writable only once the length is known to fit.
                        wp_d    = 1'b0;
                        state_d = S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    lo_d    = rx_data;
                    state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    wr_data_d = rx_word;
                    wr_addr_d = ROM_START + ww_q;
                    wr_en_d   = 1'b1;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_ready) begin
                    wr_en_d = 1'b0;
                    ww_d    = ww_q + WIDTH'(1);
                    csum_d  = csum_add(csum_q, wr_data_q);
                    state_d = ((ww_q + WIDTH'(1)) == len_q) ? S_CSUM_LO : S_DATA_LO;
                end
            end
            S_CSUM_LO: begin
                if (accept) begin
                    lo_d    = rx_data;
                    state_d = S_CSUM_HI;
                end
            end
            S_CSUM_HI: begin
                if (accept) begin
                    wp_d = 1'b1;
                    if (rx_word == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                wp_d    = 1'b1;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_addr_q <= ROM_START;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            wp_q      <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ww_q      <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            wp_q      <= wp_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ww_q      <= ww_d;
        end
    end

    // Scratch fields are always written before use within a frame.
    always_ff @(posedge clk) begin
        len_q  <= len_d;
        lo_q   <= lo_d;
        csum_q <= csum_d;
    end

    assign rx_ready      = rx_ready_c;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign wr_en         = wr_en_q;
    assign write_protect = wp_q;
    assign busy          = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: table of whole frames plus hand-written
// backpressure, enable and mid-frame reset sequences.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        wr_ready;
    logic        write_protect;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    rom_loader dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .wr_ready      (wr_ready),
        .write_protect (write_protect),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [95:0] bytes;
        logic [7:0]  n;
        logic [7:0]  nwr;
        logic [15:0] a0;
        logic [15:0] d0;
        logic [15:0] a1;
        logic [15:0] d1;
        logic        done;
        logic        err;
        logic [15:0] ww;
        logic        drop;
    } vec_t;

    vec_t        vecs [4];
    int          vec_n = 0;
    int          miss_n = 0;
    int          byte_cnt = 0;
    int          wp_bad = 0;
    bit          wp_seen_low = 0;
    logic [15:0] log_a [$];
    logic [15:0] log_d [$];

    always @(posedge clk) begin
        if (!reset && wr_en && wr_ready) begin
            log_a.push_back(wr_addr);
            log_d.push_back(wr_data);
        end
        if (rx_valid && rx_ready) byte_cnt++;
    end

    always @(negedge clk) begin
        if (!write_protect) begin
            wp_seen_low = 1'b1;
            if (!busy) wp_bad++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input bit sel_addr, input int k);
        if (k < log_a.size()) return sel_addr ? 32'(log_a[k]) : 32'(log_d[k]);
        return 32'hFFFF_FFFF;
    endfunction

    // Called just after a falling edge; returns just after the falling edge that
    // follows the rising edge which consumed the byte.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            vec_n++;
            miss_n++;
            $display("FAIL send_timeout byte %h: rx_ready got 0, expected 1", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        log_a.delete();
        log_d.delete();
        wp_seen_low = 1'b0;
        for (int i = 0; i < int'(v.n); i++) send(v.bytes[8*(int'(v.n)-1-i) +: 8]);
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d.nwr", idx), log_a.size(), 32'(v.nwr));
        for (int k = 0; k < int'(v.nwr); k++) begin
            chk($sformatf("v%0d.addr%0d", idx, k), log_at(1'b1, k), 32'(k == 0 ? v.a0 : v.a1));
            chk($sformatf("v%0d.data%0d", idx, k), log_at(1'b0, k), 32'(k == 0 ? v.d0 : v.d1));
        end
        chk($sformatf("v%0d.done", idx), 32'(done), 32'(v.done));
        chk($sformatf("v%0d.error", idx), 32'(error), 32'(v.err));
        chk($sformatf("v%0d.words_written", idx), 32'(words_written), 32'(v.ww));
        chk($sformatf("v%0d.write_protect", idx), 32'(write_protect), 32'd1);
        chk($sformatf("v%0d.busy", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d.wp_dropped", idx), 32'(wp_seen_low), 32'(v.drop));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time expired, expected completion");
        $fatal(1);
    end

    initial begin
        int bc0;

        vecs[0] = '{bytes: 96'hB4_02_00_34_12_CD_AB_01_BE, n: 8'd9, nwr: 8'd2,
                    a0: 16'h0000, d0: 16'h1234, a1: 16'h0001, d1: 16'hABCD,
                    done: 1'b1, err: 1'b0, ww: 16'd2, drop: 1'b1};
        vecs[1] = '{bytes: 96'hB4_00_00_00_00, n: 8'd5, nwr: 8'd0,
                    a0: 16'h0, d0: 16'h0, a1: 16'h0, d1: 16'h0,
                    done: 1'b1, err: 1'b0, ww: 16'd0, drop: 1'b0};
        vecs[2] = '{bytes: 96'hB4_01_00_01_00_02_00, n: 8'd7, nwr: 8'd1,
                    a0: 16'h0000, d0: 16'h0001, a1: 16'h0, d1: 16'h0,
                    done: 1'b0, err: 1'b1, ww: 16'd1, drop: 1'b1};
        vecs[3] = '{bytes: 96'hB4_01_80, n: 8'd3, nwr: 8'd0,
                    a0: 16'h0, d0: 16'h0, a1: 16'h0, d1: 16'h0,
                    done: 1'b0, err: 1'b1, ww: 16'd0, drop: 1'b0};

        reset    = 1'b1;
        enable   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.rx_ready", 32'(rx_ready), 32'd0);
        chk("rst.wr_en", 32'(wr_en), 32'd0);
        chk("rst.wr_addr", 32'(wr_addr), 32'h0000);
        chk("rst.wr_data", 32'(wr_data), 32'h0000);
        chk("rst.write_protect", 32'(write_protect), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.error", 32'(error), 32'd0);
        chk("rst.words_written", 32'(words_written), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Disabled loader must not take even a sync byte.
        bc0      = byte_cnt;
        rx_data  = 8'hB4;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("dis.rx_ready", 32'(rx_ready), 32'd0);
        chk("dis.busy", 32'(busy), 32'd0);
        chk("dis.bytes_taken", 32'(byte_cnt - bc0), 32'd0);
        rx_valid = 1'b0;
        enable   = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Backpressure on the first write of a good 2-word frame.
        log_a.delete();
        log_d.delete();
        wr_ready = 1'b0;
        send(8'hB4); send(8'h02); send(8'h00); send(8'h34); send(8'h12);
        rx_data  = 8'hCD;
        rx_valid = 1'b1;
        bc0      = byte_cnt;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d.wr_en", c), 32'(wr_en), 32'd1);
            chk($sformatf("bp%0d.wr_addr", c), 32'(wr_addr), 32'h0000);
            chk($sformatf("bp%0d.wr_data", c), 32'(wr_data), 32'h1234);
            chk($sformatf("bp%0d.rx_ready", c), 32'(rx_ready), 32'd0);
            @(negedge clk);
        end
        chk("bp.bytes_taken", 32'(byte_cnt - bc0), 32'd0);
        wr_ready = 1'b1;
        @(negedge clk);
        chk("bp.wr_en_drop", 32'(wr_en), 32'd0);
        send(8'hCD); send(8'hAB); send(8'h01); send(8'hBE);
        repeat (4) @(negedge clk);
        chk("bp.nwr", log_a.size(), 32'd2);
        chk("bp.data0", log_at(1'b0, 0), 32'h1234);
        chk("bp.addr1", log_at(1'b1, 1), 32'h0001);
        chk("bp.data1", log_at(1'b0, 1), 32'hABCD);
        chk("bp.done", 32'(done), 32'd1);
        chk("bp.write_protect", 32'(write_protect), 32'd1);

        // Reset while word 1 is waiting in WRITE, with wr_ready high in the reset cycle.
        log_a.delete();
        log_d.delete();
        send(8'hB4); send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'hCD);
        wr_ready = 1'b0;
        send(8'hAB);
        chk("mr.pre_wr_en", 32'(wr_en), 32'd1);
        chk("mr.pre_write_protect", 32'(write_protect), 32'd0);
        reset    = 1'b1;
        wr_ready = 1'b1;
        enable   = 1'b0;
        @(negedge clk);
        chk("mr.wr_en", 32'(wr_en), 32'd0);
        chk("mr.write_protect", 32'(write_protect), 32'd1);
        chk("mr.busy", 32'(busy), 32'd0);
        chk("mr.rx_ready", 32'(rx_ready), 32'd0);
        chk("mr.words_written", 32'(words_written), 32'd0);
        chk("mr.wr_addr", 32'(wr_addr), 32'h0000);
        chk("mr.wr_data", 32'(wr_data), 32'h0000);
        chk("mr.done", 32'(done), 32'd0);
        chk("mr.nwr", log_a.size(), 32'd1);
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        send(8'h55);
        send(8'hAA);
        chk("mr.junk_busy", 32'(busy), 32'd0);
        run_vec(vecs[0], 4);

        chk("wp_low_outside_load", wp_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time programming stage that sits directly upstream of the program ROM.
- Consumes a byte stream from the serial receiver and assembles it into 16-bit words.
- Issues ROM write requests (address, data, strobe) and owns the ROM write_protect line.
- Holds the ROM writable only during a validated load, then re-protects it and reports done or error.

Parameters:
- WIDTH, 16, bus word width in bits; must be 16.
- ROM_START, 16'h0000, bus address of ROM word 0.
- DEPTH, 32768, ROM size in words; maximum accepted load length.
- SYNC_BYTE, 8'hB4, frame start marker.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  arms the loader; when low, the loader stays in IDLE and ignores bytes.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  byte accepted when rx_valid && rx_ready.
- wr_addr  output  WIDTH  ROM write address.
- wr_data  output  WIDTH  ROM write data.
- wr_en  output  1  write request; held until wr_ready.
- wr_ready  input  1  write accepted this cycle.
- write_protect  output  1  to ROM; low only while a load is in progress.
- busy  output  1  high in every state except IDLE, DONE, ERROR.
- done  output  1  load completed with good checksum; sticky.
- error  output  1  bad length or checksum; sticky.
- words_written  output  WIDTH  count of accepted ROM writes in the current frame.

Behaviour:
- Reset values:
  - rx_ready=0, wr_en=0, wr_addr=ROM_START, wr_data=0.
  - write_protect=1, busy=0, done=0, error=0, words_written=0.
  - State IDLE.
- Frame format, all fields little-endian: SYNC_BYTE, LEN_LO, LEN_HI, then LEN words (lo, hi), then CSUM_LO, CSUM_HI.
  - CSUM = sum of data words mod 2^16.
- States:
  - IDLE:
    - rx_ready = enable.
    - A byte equal to SYNC_BYTE goes to LEN_LO and clears done, error and words_written.
    - Any other byte is discarded.
  - LEN_LO, LEN_HI:
    - Capture the length.
    - After LEN_HI, LEN > DEPTH goes to ERROR.
    - LEN == 0 goes to CSUM_LO.
    - Otherwise drop write_protect to 0 and go to DATA_LO.
  - DATA_LO, DATA_HI:
    - Assemble the word.
    - Accepting the HI byte loads wr_data and sets wr_en=1 on the next cycle.
    - wr_addr = ROM_START + words_written.
    - Go to WRITE.
  - WRITE:
    - rx_ready=0; wr_en held with stable wr_addr and wr_data until wr_ready.
    - On the wr_ready cycle: wr_en drops next cycle, words_written increments, checksum accumulates the word.
    - If words_written+1 == LEN, go to CSUM_LO; else go to DATA_LO.
  - CSUM_LO, CSUM_HI:
    - After CSUM_HI, set write_protect=1.
    - Match goes to DONE (done=1); mismatch goes to ERROR (error=1).
  - DONE, ERROR:
    - rx_ready = enable.
    - A SYNC_BYTE starts a new frame exactly as from IDLE; other bytes are discarded.
- rx_ready is 1 in LEN/DATA/CSUM states regardless of enable. Deasserting enable mid-frame does not abort.
- Timing and latency:
  - At most one byte per cycle.
  - Minimum of 1 cycle from wr_en rising to the next rx_ready; wr_ready is permitted in the first wr_en cycle.
- Checksum and address arithmetic are modulo 2^16; no overflow is possible because LEN <= DEPTH.
- write_protect is never 0 outside DATA_LO through CSUM_HI, including after ERROR.
- Reset mid-frame: next cycle every output is at its reset value.
  - A write in progress is dropped (wr_en=0 even if wr_ready is high in the reset cycle).
  - The partial ROM contents are not rolled back.
- Idle bytes: rx_valid with rx_ready low is neither consumed nor counted.

Test Plan:
- Good 2-word load: B4 02 00 34 12 CD AB 01 BE.
  - Expect wr (0000, 1234) and (0001, ABCD).
  - Then write_protect returns to 1, done=1, words_written=2.
- Zero-length frame: B4 00 00 00 00 -> no wr_en, write_protect stays 1 throughout, done=1.
- Bad checksum: B4 01 00 01 00 02 00.
  - Expect one write (0000, 0001), then error=1, done=0, write_protect=1.
- Over-length: B4 01 80 (LEN=32769) -> error=1, write_protect never drops, no writes.
- Backpressure: hold wr_ready=0 for 5 cycles on the first write.
  - wr_en, wr_addr and wr_data stay stable; rx_ready stays 0; the queued byte is not consumed.
  - Load completes normally afterwards.
- Reset mid-frame: assert reset during WRITE of word 1.
  - Next cycle wr_en=0, write_protect=1, busy=0.
  - Leading junk 55 AA then a good frame loads correctly.
